// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl
//   Turns the level-sensitive 16-bit key vector from the keypad scanner into
//   a stream of debounced key events, buffered in a small FIFO and drained
//   over a valid/ready handshake.
//
//   Pipeline: debounce (raw_q/cnt_q -> stable_q), edge detect against
//   stable_prev_q, pending masks, lowest-index arbiter, circular FIFO.
//
// Parameters
//   DEBOUNCE  cycles keys must stay unchanged before being accepted (>= 2)
//   DEPTH     event FIFO depth (power of 2, >= 2)
//
// Ports
//   clk        single clock
//   rst_l      asynchronous active-low reset
//   keys       one bit per key, 1 = pressed, bit index = key code
//   evt_valid  FIFO non-empty, evt_code holds the head event
//   evt_code   {release flag, key code[3:0]}
//   evt_ready  consumer accepts the head event
//   evt_count  FIFO occupancy
//   ovf        sticky: a key edge was lost (duplicate while still pending)
//   clr_ovf    synchronous clear of ovf (a same-cycle new overflow wins)
//
// Build option
//   KEYPAD_RELEASE_EVT_EN  when defined, release edges generate events with
//                          evt_code[4] = 1; presses have priority. When
//                          undefined only press events exist and
//                          evt_code[4] is tied to 0.

module keypad_event_ctrl #(
  parameter int DEBOUNCE = 2_000_000,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [15:0]              keys,
  output logic                     evt_valid,
  output logic [4:0]               evt_code,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [15:0]   raw_q, raw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   stable_q, stable_d;
  logic [15:0]   stable_prev_q;
  logic [15:0]   press;
  logic [15:0]   pend_p_q, pend_p_d, grant_p, lost;
  logic [3:0]    idx_p;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] push_code, head;
  logic          full, empty, any_pend, push, pop;

`ifdef KEYPAD_RELEASE_EVT_EN
  logic [15:0]   rel, pend_r_q, pend_r_d, grant_r;
  logic [3:0]    idx_r;
  assign rel      = ~stable_q & stable_prev_q;
  assign any_pend = (|pend_p_q) || (|pend_r_q);
`else
  assign any_pend = |pend_p_q;
`endif

  // ---- debounce stage: any change restarts the hold counter ----
  always_comb begin
    raw_d    = raw_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (keys != raw_q) begin
      raw_d = keys;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      stable_d = raw_q;
    end
  end

  // ---- edge detect stage ----
  assign press = stable_q & ~stable_prev_q;

  // ---- FIFO status from registered pointers only ----
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  assign evt_count = wptr_q - rptr_q;

  // ---- pending masks and arbiter stage ----
  always_comb begin
    idx_p     = lowest_idx(pend_p_q);
    push      = !full && any_pend;
    grant_p   = '0;
    push_code = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
    idx_r   = lowest_idx(pend_r_q);
    grant_r = '0;
`endif
    if (push) begin
      if (|pend_p_q) begin
        grant_p   = 16'b1 << idx_p;
        push_code = EW'(idx_p);
`ifdef KEYPAD_RELEASE_EVT_EN
      end else begin
        grant_r   = 16'b1 << idx_r;
        push_code = {1'b1, idx_r};
`endif
      end
    end
    // A pending bit that was not granted cannot hold a second edge; that
    // edge is dropped and flagged. Bits held while the FIFO is full are
    // never lost on their own.
    pend_p_d = (pend_p_q & ~grant_p) | press;
    lost     = press & pend_p_q & ~grant_p;
`ifdef KEYPAD_RELEASE_EVT_EN
    pend_r_d = (pend_r_q & ~grant_r) | rel;
    lost     = lost | (rel & pend_r_q & ~grant_r);
`endif
    if (|lost)        ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      raw_q         <= '0;
      cnt_q         <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      pend_p_q      <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
      pend_r_q      <= '0;
`endif
      ovf_q         <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      raw_q         <= raw_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      pend_p_q      <= pend_p_d;
`ifdef KEYPAD_RELEASE_EVT_EN
      pend_r_q      <= pend_r_d;
`endif
      ovf_q         <= ovf_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  // ---- FIFO storage stage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= push_code;
  end

  assign head = mem_q[rptr_q[AW-1:0]];
  assign ovf  = ovf_q;

  // Storage is not reset, so the head is masked while the FIFO is empty.
`ifdef KEYPAD_RELEASE_EVT_EN
  assign evt_code = empty ? 5'd0 : head;
`else
  assign evt_code = empty ? 5'd0 : {1'b0, head};
`endif

endmodule
